// File: rtl/nx_node_egress_pkg.sv
// Shared payload types for the node egress router: node coordinates and the routed message.
package nx_node_egress_pkg;

   localparam int unsigned COORD_W   = 4;
   localparam int unsigned PAYLOAD_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] column;
   } node_id_t;

   typedef struct packed {
      node_id_t               target;
      logic [PAYLOAD_W-1:0]   payload;
   } node_message_t;

   // One-hot output port select: bit 0 north, 1 east, 2 south, 3 west, 4 local.
   localparam int unsigned    NUM_DIRS  = 5;
   localparam logic [4:0]     DIR_NORTH = 5'b00001;
   localparam logic [4:0]     DIR_EAST  = 5'b00010;
   localparam logic [4:0]     DIR_SOUTH = 5'b00100;
   localparam logic [4:0]     DIR_WEST  = 5'b01000;
   localparam logic [4:0]     DIR_LOCAL = 5'b10000;

endpackage

// File: rtl/nx_node_egress.sv
// Node egress: in-order message FIFO feeding a single registered output stage,
// routed row-first onto one of five directional ports.
module nx_node_egress
   import nx_node_egress_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  node_id_t      i_node_id,
   input  node_message_t i_msg_data,
   input  logic          i_msg_valid,
   output logic          o_msg_ready,
   output node_message_t o_north_data,
   output node_message_t o_east_data,
   output node_message_t o_south_data,
   output node_message_t o_west_data,
   output node_message_t o_local_data,
   output logic          o_north_valid,
   output logic          o_east_valid,
   output logic          o_south_valid,
   output logic          o_west_valid,
   output logic          o_local_valid,
   input  logic          i_north_ready,
   input  logic          i_east_ready,
   input  logic          i_south_ready,
   input  logic          i_west_ready,
   input  logic          i_local_ready,
   output logic          o_idle
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   node_message_t         mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [NUM_DIRS-1:0]   out_vld, out_vld_nxt, port_ready;
   node_message_t         out_data, head;
   logic                  msg_ready_q, idle_q;
   logic                  empty, push, pop, handshake, full_nxt, empty_nxt;

   // Row first, then column; coordinates compare unsigned.
   function automatic logic [NUM_DIRS-1:0] route(input node_id_t here, input node_id_t tgt);
      logic [NUM_DIRS-1:0] dir;
      dir = DIR_LOCAL;
      if (tgt.row > here.row)             dir = DIR_SOUTH;
      else if (tgt.row < here.row)        dir = DIR_NORTH;
      else if (tgt.column > here.column)  dir = DIR_EAST;
      else if (tgt.column < here.column)  dir = DIR_WEST;
      return dir;
   endfunction

   always_comb begin
      port_ready  = {i_local_ready, i_west_ready, i_south_ready, i_east_ready, i_north_ready};
      empty       = (wr_ptr == rd_ptr);
      head        = mem[rd_ptr[AW-1:0]];
      handshake   = |(out_vld & port_ready);
      push        = i_msg_valid && msg_ready_q;
      pop         = !empty && (!(|out_vld) || handshake);
      wr_ptr_nxt  = push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_nxt  = pop  ? rd_ptr + PW'(1) : rd_ptr;
      out_vld_nxt = out_vld;
      if (pop)            out_vld_nxt = route(i_node_id, head.target);
      else if (handshake) out_vld_nxt = '0;
      // Wrap bit differs with equal index bits -> full.
      full_nxt    = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      empty_nxt   = (wr_ptr_nxt == rd_ptr_nxt);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         out_vld     <= '0;
         out_data    <= '0;
         msg_ready_q <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         out_vld     <= out_vld_nxt;
         if (pop) out_data <= head;
         msg_ready_q <= !full_nxt;
         idle_q      <= empty_nxt && !(|out_vld_nxt);
      end
   end

   // Storage needs no reset: pointers define which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= i_msg_data;
   end

   assign o_msg_ready   = msg_ready_q;
   assign o_idle        = idle_q;
   assign o_north_data  = out_data;
   assign o_east_data   = out_data;
   assign o_south_data  = out_data;
   assign o_west_data   = out_data;
   assign o_local_data  = out_data;
   assign o_north_valid = out_vld[0];
   assign o_east_valid  = out_vld[1];
   assign o_south_valid = out_vld[2];
   assign o_west_valid  = out_vld[3];
   assign o_local_valid = out_vld[4];

endmodule

// File: tb/tb_nx_node_egress.sv
// Self-checking bench for nx_node_egress: directed scenarios plus randomized traffic
// against a queue-based reference model of the buffered message stream.
module tb_nx_node_egress;
   import nx_node_egress_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   node_id_t      node_id;
   node_message_t msg_data;
   logic          msg_valid, msg_ready, idle;
   node_message_t n_data, e_data, s_data, w_data, l_data;
   logic          n_valid, e_valid, s_valid, w_valid, l_valid;
   logic [4:0]    rdy;
   logic [4:0]    vld;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign vld = {l_valid, w_valid, s_valid, e_valid, n_valid};

   nx_node_egress #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_node_id(node_id),
      .i_msg_data(msg_data), .i_msg_valid(msg_valid), .o_msg_ready(msg_ready),
      .o_north_data(n_data), .o_east_data(e_data), .o_south_data(s_data),
      .o_west_data(w_data), .o_local_data(l_data),
      .o_north_valid(n_valid), .o_east_valid(e_valid), .o_south_valid(s_valid),
      .o_west_valid(w_valid), .o_local_valid(l_valid),
      .i_north_ready(rdy[0]), .i_east_ready(rdy[1]), .i_south_ready(rdy[2]),
      .i_west_ready(rdy[3]), .i_local_ready(rdy[4]),
      .o_idle(idle)
   );

   // Reference model: every accepted, undelivered message in order; fcnt of them
   // still sit in the buffer, and opres says whether the oldest one is on the output.
   node_message_t mq[$];
   int            fcnt = 0;
   bit            opres = 1'b0;
   bit            rst_seen = 1'b1;

   function automatic logic [4:0] dir_of(input node_id_t here, input node_id_t t);
      if (t.row > here.row)       return 5'b00100;
      if (t.row < here.row)       return 5'b00001;
      if (t.column > here.column) return 5'b00010;
      if (t.column < here.column) return 5'b01000;
      return 5'b10000;
   endfunction

   function automatic logic [4:0] exp_vld();
      return opres ? dir_of(node_id, mq[0].target) : 5'b0;
   endfunction

   function automatic bit exp_ready();
      return !rst_seen && (fcnt < int'(DEPTH));
   endfunction

   function automatic bit exp_idle();
      return (fcnt == 0) && !opres;
   endfunction

   function automatic bit data_ok();
      return (n_data === mq[0]) && (e_data === mq[0]) && (s_data === mq[0]) &&
             (w_data === mq[0]) && (l_data === mq[0]);
   endfunction

   function automatic node_message_t rand_msg(input node_id_t here);
      node_message_t m;
      m.target.row    = ($urandom % 2 == 0) ? here.row    : 4'($urandom);
      m.target.column = ($urandom % 2 == 0) ? here.column : 4'($urandom);
      m.payload       = 16'($urandom);
      return m;
   endfunction

   // Advance one clock edge, updating the model from the inputs applied this cycle.
   task automatic tick();
      bit hs, push, pop;
      @(posedge clk);
      if (!rst) begin
         mq.delete();
         fcnt     = 0;
         opres    = 1'b0;
         rst_seen = 1'b1;
      end else begin
         hs   = opres && ((rdy & dir_of(node_id, mq[0].target)) != 5'b0);
         push = msg_valid && exp_ready();
         pop  = (fcnt > 0) && (!opres || hs);
         if (hs)   void'(mq.pop_front());
         if (push) mq.push_back(msg_data);
         fcnt = fcnt + int'(push) - int'(pop);
         if (pop)     opres = 1'b1;
         else if (hs) opres = 1'b0;
         rst_seen = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; msg_valid = 1'b0; rdy = 5'b0; msg_data = '0;
      node_id = {4'd2, 4'd3};
      tick(); tick();
      checks++;
      if (msg_ready !== 1'b0 || vld !== 5'b0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_hold ready=%b vld=%b idle=%b want 0 00000 1", msg_ready, vld, idle);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (msg_ready !== 1'b1 || idle !== 1'b1 || vld !== 5'b0) begin
         errors++;
         $display("FAIL reset_release ready=%b idle=%b vld=%b want 1 1 00000", msg_ready, idle, vld);
      end
   endtask

   task automatic test_single();
      node_message_t m;
      rdy = 5'b11111; node_id = {4'd2, 4'd3};
      m = {4'd2, 4'd3, 16'($urandom)};
      msg_data = m; msg_valid = 1'b1;
      tick();
      msg_valid = 1'b0;
      checks++;
      if (vld !== 5'b0) begin
         errors++; $display("FAIL single_early vld=%b want 00000", vld);
      end
      tick();
      checks++;
      if (vld !== 5'b10000 || l_data !== m) begin
         errors++; $display("FAIL single_local vld=%b data=%h want 10000 %h", vld, l_data, m);
      end
      tick();
      checks++;
      if (vld !== 5'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL single_after vld=%b idle=%b want 00000 1", vld, idle);
      end
   endtask

   task automatic test_routing();
      node_message_t tg [4];
      logic [4:0]    want [4];
      logic [4:0]    seen [$];
      int            k = 0;
      bit            acc;
      rdy = 5'b11111; node_id = {4'd2, 4'd3};
      tg[0] = {4'd0, 4'd3, 16'h1111}; want[0] = 5'b00001;
      tg[1] = {4'd5, 4'd3, 16'h2222}; want[1] = 5'b00100;
      tg[2] = {4'd2, 4'd7, 16'h3333}; want[2] = 5'b00010;
      tg[3] = {4'd2, 4'd0, 16'h4444}; want[3] = 5'b01000;
      for (int c = 0; c < 10; c++) begin
         msg_valid = (k < 4);
         if (k < 4) msg_data = tg[k];
         acc = msg_valid && msg_ready;
         tick();
         if (acc) k++;
         if (vld != 5'b0) seen.push_back(vld);
      end
      msg_valid = 1'b0;
      checks++;
      if (seen.size() != 4) begin
         errors++; $display("FAIL route_count got=%0d want 4", seen.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
               errors++; $display("FAIL route_dir%0d got=%b want %b", i, seen[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      node_message_t sent [6];
      node_message_t got [$];
      int            k = 0;
      bit            acc;
      rdy = 5'b0; node_id = {4'd2, 4'd3};
      for (int i = 0; i < 6; i++) sent[i] = rand_msg(node_id);
      for (int c = 0; c < 10; c++) begin
         msg_valid = (k < 6);
         if (k < 6) msg_data = sent[k];
         acc = msg_valid && msg_ready;
         tick();
         if (acc) k++;
         checks++;
         if (vld !== exp_vld() || msg_ready !== exp_ready() || idle !== exp_idle()) begin
            errors++;
            $display("FAIL bp_model c%0d vld=%b/%b rdy=%b/%b idle=%b/%b", c, vld, exp_vld(),
                     msg_ready, exp_ready(), idle, exp_idle());
         end
      end
      checks++;
      if (k != 5 || msg_ready !== 1'b0) begin
         errors++; $display("FAIL bp_full accepted=%0d ready=%b want 5 0", k, msg_ready);
      end
      checks++;
      if (!$onehot(vld) || n_data !== sent[0]) begin
         errors++; $display("FAIL bp_head vld=%b data=%h want onehot %h", vld, n_data, sent[0]);
      end
      msg_valid = 1'b0; rdy = 5'b11111;
      for (int c = 0; c < 12; c++) begin
         if (vld != 5'b0) got.push_back(n_data);
         tick();
      end
      checks++;
      if (got.size() != 5) begin
         errors++; $display("FAIL bp_drain_count got=%0d want 5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
               errors++; $display("FAIL bp_order%0d got=%h want %h", i, got[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_streaming();
      int k = 0;
      rdy = 5'b11111;
      node_id = {4'($urandom), 4'($urandom)};
      for (int i = 0; i < 20; i++) begin
         msg_valid = (k < 16);
         if (k < 16) msg_data = rand_msg(node_id);
         tick();
         if (k < 16) k++;
         checks++;
         if (msg_ready !== 1'b1 || (vld != 5'b0) !== (i >= 1 && i <= 16)) begin
            errors++;
            $display("FAIL stream_c%0d ready=%b vld=%b want 1 and valid=%b", i, msg_ready, vld,
                     (i >= 1 && i <= 16));
         end
         checks++;
         if (vld !== exp_vld() || (exp_vld() != 5'b0 && !data_ok())) begin
            errors++; $display("FAIL stream_model_c%0d vld=%b want %b data=%h", i, vld, exp_vld(), n_data);
         end
      end
      msg_valid = 1'b0;
   endtask

   task automatic test_hold();
      node_message_t a, b;
      node_id = {4'd2, 4'd3};
      rdy = 5'b11101;
      a = {4'd2, 4'd7, 16'($urandom)};
      b = {4'd0, 4'd0, 16'($urandom)};
      msg_data = a; msg_valid = 1'b1;
      tick();
      msg_data = b;
      tick();
      msg_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (vld !== 5'b00010 || e_data !== a || msg_ready !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL hold_c%0d vld=%b data=%h ready=%b idle=%b want 00010 %h 1 0", c, vld,
                     e_data, msg_ready, idle, a);
         end
      end
      rdy = 5'b11111;
      tick();
      checks++;
      if (vld !== 5'b00001 || n_data !== b) begin
         errors++; $display("FAIL hold_next vld=%b data=%h want 00001 %h", vld, n_data, b);
      end
      tick();
      checks++;
      if (vld !== 5'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL hold_drain vld=%b idle=%b want 00000 1", vld, idle);
      end
   endtask

   task automatic test_mid_reset();
      node_id = {4'd2, 4'd3}; rdy = 5'b0;
      for (int i = 0; i < 3; i++) begin
         msg_data = rand_msg(node_id); msg_valid = 1'b1;
         tick();
      end
      msg_valid = 1'b0; rst = 1'b0;
      tick();
      checks++;
      if (vld !== 5'b0 || idle !== 1'b1 || msg_ready !== 1'b0) begin
         errors++; $display("FAIL midrst vld=%b idle=%b ready=%b want 00000 1 0", vld, idle, msg_ready);
      end
      rst = 1'b1; rdy = 5'b11111;
      tick();
      checks++;
      if (msg_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_ready ready=%b want 1", msg_ready);
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (vld !== 5'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL midrst_stale_c%0d vld=%b idle=%b want 00000 1", c, vld, idle);
         end
      end
   endtask

   task automatic test_random();
      node_id = {4'($urandom), 4'($urandom)};
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom % 97) != 0;
         rdy       = 5'($urandom) & {5{($urandom % 2) == 1}};
         msg_valid = ($urandom % 4) != 0;
         msg_data  = rand_msg(node_id);
         tick();
         checks++;
         if (vld !== exp_vld() || msg_ready !== exp_ready() || idle !== exp_idle()) begin
            errors++;
            $display("FAIL rand_c%0d vld=%b/%b rdy=%b/%b idle=%b/%b", c, vld, exp_vld(),
                     msg_ready, exp_ready(), idle, exp_idle());
         end
         if (exp_vld() != 5'b0) begin
            checks++;
            if (!data_ok()) begin
               errors++; $display("FAIL rand_data_c%0d got=%h want %h", c, n_data, mq[0]);
            end
         end
      end
      rst = 1'b1; msg_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_routing();
      test_backpressure();
      test_streaming();
      test_hold();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
